// File: rtl/cache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate data cache with multi-word lines,
// big-endian byte/half lanes, a word-serial refill/writeback port and hit/miss counters.
module cache_wb_ctrl #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 9,
    parameter int WPL        = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    output logic [XLEN-1:0]   cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int OFF_BITS = (WPL > 1) ? $clog2(WPL) : 0;
    localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int TAG_W    = ADDR_W - INDEX_BITS - OFF_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = LINES * WPL;
    localparam int WIDX_W   = INDEX_BITS + OFF_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WB     = 2'd2,
        S_FILL   = 2'd3
    } state_e;

    // Byte 0 is the most significant lane; sub-word loads are sign-extended.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] w,
        input logic [1:0]      size,
        input logic [1:0]      boff
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (boff)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = boff[1] ? w[15:0] : w[31:16];
        case (size)
            2'd0:    r = {{24{b[7]}}, b};
            2'd1:    r = {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0] w,
        input logic [XLEN-1:0] wd,
        input logic [1:0]      size,
        input logic [1:0]      boff
    );
        logic [XLEN-1:0] r;
        r = w;
        case (size)
            2'd0: begin
                case (boff)
                    2'd0:    r[31:24] = wd[7:0];
                    2'd1:    r[23:16] = wd[7:0];
                    2'd2:    r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            2'd1: begin
                if (boff[1]) begin
                    r[15:0] = wd[15:0];
                end else begin
                    r[31:16] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [TAG_W-1:0]  t,
        input logic [WIDX_W-1:0] wi
    );
        return (ADDR_W'(t) << (ADDR_W - TAG_W)) | (ADDR_W'(wi) << 2);
    endfunction

    logic [XLEN-1:0]  data_q [WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q, dirty_q;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              refill_q, refill_d;
    logic              req_we_q, req_we_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]      req_tag_s;
    logic [INDEX_BITS-1:0] idx_s;
    logic [WIDX_W-1:0]     rd_widx_s;
    logic [WIDX_W-1:0]     beat_widx_s;
    logic [XLEN-1:0]       cur_word_s;
    logic [XLEN-1:0]       beat_word_s;
    logic                  hit_s;
    logic                  last_beat_s;
    logic                  data_we_s;
    logic [WIDX_W-1:0]     data_waddr_s;
    logic [XLEN-1:0]       data_wdata_s;
    logic                  set_dirty_s;
    logic                  fill_done_s;

    assign req_tag_s   = req_addr_q[ADDR_W-1 -: TAG_W];
    assign idx_s       = req_addr_q[2+OFF_BITS +: INDEX_BITS];
    assign rd_widx_s   = req_addr_q[2 +: WIDX_W];
    assign beat_widx_s = (WIDX_W'(idx_s) << OFF_BITS) | WIDX_W'(beat_q);
    assign cur_word_s  = data_q[rd_widx_s];
    assign beat_word_s = data_q[beat_widx_s];
    assign hit_s       = valid_q[idx_s] && (tag_q[idx_s] == req_tag_s);
    assign last_beat_s = (beat_q == OFF_W'(WPL - 1));
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

    // Next-state, request capture, counters and all port outputs.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        refill_d     = refill_q;
        req_we_d     = req_we_q;
        req_size_d   = req_size_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        data_we_s    = 1'b0;
        data_waddr_s = rd_widx_s;
        data_wdata_s = '0;
        set_dirty_s  = 1'b0;
        fill_done_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_size_d  = cpu_size;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    refill_d    = 1'b0;
                    state_d     = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                // Only the first lookup of a request is counted; the post-refill one always hits.
                if (!refill_q) begin
                    if (hit_s) begin
                        hit_cnt_d = (hit_cnt_q != 32'hFFFF_FFFF) ? hit_cnt_q + 32'd1 : hit_cnt_q;
                    end else begin
                        miss_cnt_d = (miss_cnt_q != 32'hFFFF_FFFF) ? miss_cnt_q + 32'd1 : miss_cnt_q;
                    end
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
                if (hit_s) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = load_extract(cur_word_s, req_size_q, req_addr_q[1:0]);
                    if (req_we_q) begin
                        data_we_s    = 1'b1;
                        data_waddr_s = rd_widx_s;
                        data_wdata_s = store_merge(cur_word_s, req_wdata_q, req_size_q, req_addr_q[1:0]);
                        set_dirty_s  = 1'b1;
                    end else begin
                        data_we_s = 1'b0;
                    end
                    state_d = S_IDLE;
                end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
                    beat_d  = '0;
                    state_d = S_WB;
                end else begin
                    beat_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = beat_addr(tag_q[idx_s], beat_widx_s);
                mem_wdata = beat_word_s;
                if (mem_ack) begin
                    if (last_beat_s) begin
                        beat_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = beat_addr(req_tag_s, beat_widx_s);
                if (mem_ack) begin
                    data_we_s    = 1'b1;
                    data_waddr_s = beat_widx_s;
                    data_wdata_s = mem_rdata;
                    if (last_beat_s) begin
                        fill_done_s = 1'b1;
                        refill_d    = 1'b1;
                        beat_d      = '0;
                        state_d     = S_LOOKUP;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control state and line status; reset drops any in-flight burst.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            refill_q    <= 1'b0;
            req_we_q    <= 1'b0;
            req_size_q  <= 2'd0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            refill_q    <= refill_d;
            req_we_q    <= req_we_d;
            req_size_q  <= req_size_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (fill_done_s) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end else if (set_dirty_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
        end
    end

    // Data and tag storage, deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_b && data_we_s) begin
            data_q[data_waddr_s] <= data_wdata_s;
        end
        if (!rst_b && fill_done_s) begin
            tag_q[idx_s] <= req_tag_s;
        end
    end

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// Scoreboard bench for cache_wb_ctrl: expected load data queued at issue and
// compared when cpu_ready pulses; a memory model checks every writeback/refill beat.
`timescale 1ns/1ps
module tb_cache_wb_ctrl;

    localparam int XLEN       = 32;
    localparam int ADDR_W     = 32;
    localparam int INDEX_BITS = 9;
    localparam int WPL        = 4;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              cpu_req, cpu_we;
    logic [1:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [XLEN-1:0]   cpu_wdata, cpu_rdata;
    logic              cpu_ready;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;
    logic [31:0]       hit_cnt, miss_cnt;

    cache_wb_ctrl #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .INDEX_BITS(INDEX_BITS), .WPL(WPL)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_wb[$];
    logic [31:0] exp_fill[$];
    logic [31:0] mem_model [logic [31:0]];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [31:0] exp_hits = 32'd0;
    logic [31:0] exp_miss = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic push_fills(input logic [31:0] base);
        for (int i = 0; i < WPL; i++) exp_fill.push_back(base + 32'(i * 4));
    endtask

    // Memory model: acks each beat after ack_delay idle cycles, checks beat order.
    initial begin
        logic [63:0] w;
        logic [31:0] f;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req !== 1'b1) begin
                wait_cnt = 0;
            end else if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_we) begin
                    if (exp_wb.size() == 0) begin
                        check_eq("wb_unexpected", 32'(exp_wb.size()), 32'd1);
                    end else begin
                        w = exp_wb.pop_front();
                        check_eq("wb_addr", mem_addr, w[63:32]);
                        check_eq("wb_data", mem_wdata, w[31:0]);
                    end
                    mem_model[mem_addr] = mem_wdata;
                end else begin
                    if (exp_fill.size() == 0) begin
                        check_eq("fill_unexpected", 32'(exp_fill.size()), 32'd1);
                    end else begin
                        f = exp_fill.pop_front();
                        check_eq("fill_addr", mem_addr, f);
                    end
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'd0;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every cpu_ready pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_ready", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) check_eq("rdata", cpu_rdata, e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic hit);
        exp_t e;
        e.rdata = exp_rd;
        e.chk   = !we;
        sb.push_back(e);
        if (hit) exp_hits = sat_inc(exp_hits);
        else     exp_miss = sat_inc(exp_miss);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_size  = size;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic hit, input int exp_lat);
        int lat;
        issue(we, size, addr, wdata, exp_rd, hit);
        lat = 1;
        while (cpu_ready !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check_eq("hit_cnt", hit_cnt, exp_hits);
        check_eq("miss_cnt", miss_cnt, exp_miss);
    endtask

    initial begin
        int t;
        rst_b     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_size  = 2'd0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        mem_model[32'h40]   = 32'h1122_3344;
        mem_model[32'h44]   = 32'h5580_6677;
        mem_model[32'h48]   = 32'h8899_AABB;
        mem_model[32'h4C]   = 32'hCCDD_EEFF;
        mem_model[32'h2040] = 32'hA1B2_C3D4;
        mem_model[32'h2044] = 32'h0102_0304;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(cpu_ready), 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_hit_cnt", hit_cnt, 32'd0);
        check_eq("rst_miss_cnt", miss_cnt, 32'd0);
        rst_b = 1'b0;
        @(negedge clk);

        // Cold miss, then sub-word hits across the line.
        push_fills(32'h40);
        do_req(1'b0, 2'd2, 32'h40, 32'd0, 32'h1122_3344, 1'b0, 6);
        do_req(1'b0, 2'd0, 32'h42, 32'd0, 32'h0000_0033, 1'b1, 1);
        do_req(1'b0, 2'd1, 32'h42, 32'd0, 32'h0000_3344, 1'b1, 1);
        do_req(1'b0, 2'd0, 32'h45, 32'd0, 32'hFFFF_FF80, 1'b1, 1);
        do_req(1'b0, 2'd1, 32'h44, 32'd0, 32'h0000_5580, 1'b1, 1);
        do_req(1'b0, 2'd1, 32'h4B, 32'd0, 32'hFFFF_AABB, 1'b1, 1);
        do_req(1'b0, 2'd0, 32'h4C, 32'd0, 32'hFFFF_FFCC, 1'b1, 1);
        do_req(1'b0, 2'd3, 32'h4F, 32'd0, 32'hCCDD_EEFF, 1'b1, 1);

        // Stores merge only their lanes and dirty the line.
        do_req(1'b1, 2'd0, 32'h43, 32'hFFFF_FFAB, 32'd0, 1'b1, 1);
        do_req(1'b0, 2'd2, 32'h40, 32'd0, 32'h1122_33AB, 1'b1, 1);
        do_req(1'b1, 2'd1, 32'h48, 32'hFFFF_1234, 32'd0, 1'b1, 1);
        do_req(1'b0, 2'd2, 32'h48, 32'd0, 32'h1234_AABB, 1'b1, 1);
        do_req(1'b1, 2'd2, 32'h4E, 32'hDEAD_BEEF, 32'd0, 1'b1, 1);
        do_req(1'b0, 2'd2, 32'h4C, 32'd0, 32'hDEAD_BEEF, 1'b1, 1);

        // Conflict miss on a dirty line: writeback then refill, then reload the victim.
        exp_wb.push_back({32'h40, 32'h1122_33AB});
        exp_wb.push_back({32'h44, 32'h5580_6677});
        exp_wb.push_back({32'h48, 32'h1234_AABB});
        exp_wb.push_back({32'h4C, 32'hDEAD_BEEF});
        push_fills(32'h2040);
        do_req(1'b0, 2'd2, 32'h2040, 32'd0, 32'hA1B2_C3D4, 1'b0, 10);
        do_req(1'b0, 2'd1, 32'h2046, 32'd0, 32'h0000_0304, 1'b1, 1);
        push_fills(32'h40);
        do_req(1'b0, 2'd2, 32'h40, 32'd0, 32'h1122_33AB, 1'b0, 6);
        check_eq("wb_left", 32'(exp_wb.size()), 32'd0);

        // Stalled refill beat holds its request, then reset abandons the burst.
        ack_delay = 5;
        push_fills(32'h100);
        issue(1'b0, 2'd2, 32'h100, 32'd0, 32'd0, 1'b0);
        t = 0;
        while (!(mem_req === 1'b1 && mem_addr === 32'h108) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("stall_reached", 32'(t < 100), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_req", 32'(mem_req), 32'd1);
            check_eq("stall_addr", mem_addr, 32'h108);
            check_eq("stall_we", 32'(mem_we), 32'd0);
            @(negedge clk);
        end
        rst_b = 1'b1;
        @(negedge clk);
        check_eq("midrst_mem_req", 32'(mem_req), 32'd0);
        check_eq("midrst_mem_addr", mem_addr, 32'd0);
        check_eq("midrst_ready", 32'(cpu_ready), 32'd0);
        check_eq("midrst_miss_cnt", miss_cnt, 32'd0);
        rst_b = 1'b0;
        sb.delete();
        exp_fill.delete();
        ack_delay = 0;
        exp_hits  = 32'd0;
        exp_miss  = 32'd0;
        @(negedge clk);
        push_fills(32'h40);
        do_req(1'b0, 2'd2, 32'h40, 32'd0, 32'h1122_33AB, 1'b0, 6);

        // Saturation of both counters via backdoor preload.
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_q;
        exp_hits = 32'hFFFF_FFFF;
        do_req(1'b0, 2'd2, 32'h44, 32'd0, 32'h5580_6677, 1'b1, 1);
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt_q;
        exp_miss = 32'hFFFF_FFFF;
        push_fills(32'h300);
        do_req(1'b0, 2'd2, 32'h300, 32'd0, 32'd0, 1'b0, 6);
        check_eq("fill_left", 32'(exp_fill.size()), 32'd0);
        check_eq("sb_left", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
